// File: rtl/tpi_ctrl.sv
// Bus-side controller for a 6523-style TPI: register decode, port strobes, read-back, IRQ/CA/CB.
// Latency: strobes combinational in the fire cycle; data_out, ILR, irq registered one clock later.
// Backpressure: none; one access per cs rising edge. `TPI_IRQ_PRIORITY_EN enables CR[1] priority AIR reads.
module tpi_ctrl #(
    parameter int PULSE_LEN   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [2:0] rs,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       we_ddr_a,
    output logic       we_ddr_b,
    output logic       we_ddr_c,
    output logic       we_port_a,
    output logic       we_port_b,
    output logic       we_port_c,
    input  logic [7:0] ddr_a,
    input  logic [7:0] ddr_b,
    input  logic [7:0] ddr_c,
    input  logic [7:0] port_a,
    input  logic [7:0] port_b,
    input  logic [7:0] port_c,
    input  logic [7:0] pins_a,
    input  logic [7:0] pins_b,
    input  logic [7:0] pins_c,
    output logic       mc,
    output logic       irq,
    output logic       ca,
    output logic       cb
);
    localparam logic [2:0] RS_PRA = 3'd0, RS_PRB = 3'd1, RS_PRC = 3'd2, RS_DDRA = 3'd3,
                           RS_DDRB = 3'd4, RS_DDRC = 3'd5, RS_CR = 3'd6, RS_AIR = 3'd7;

    logic       cs_d;
    logic       fire;
    logic       pra_acc;
    logic       prb_acc;
    logic [7:0] cr;
    logic [7:0] cr_wdat;
    logic [4:0] ilr;
    logic [4:0] ilr_nxt;
    logic [4:0] pend;
    logic [4:0] air_val;
    logic [4:0] air_clr;
    logic [4:0] fall;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] sync_prev;
    logic       hs_low;
    logic [3:0] cnt;
    logic       irq_q;
    logic [7:0] rd_dat;

    always_comb begin
        fire    = cs & ~cs_d & ~reset;
        pra_acc = fire && (rs == RS_PRA);
        prb_acc = fire && (rs == RS_PRB);

        we_port_a = fire & ~rw & (rs == RS_PRA);
        we_port_b = fire & ~rw & (rs == RS_PRB);
        we_port_c = fire & ~rw & (rs == RS_PRC);
        we_ddr_a  = fire & ~rw & (rs == RS_DDRA);
        we_ddr_b  = fire & ~rw & (rs == RS_DDRB);
        we_ddr_c  = fire & ~rw & (rs == RS_DDRC);

        mc      = cr[0];
        cr_wdat = data_in;
`ifndef TPI_IRQ_PRIORITY_EN
        cr_wdat[1] = 1'b0;
`endif

        pend    = ilr & ddr_c[4:0];
        air_val = pend;
`ifdef TPI_IRQ_PRIORITY_EN
        // Later iterations overwrite earlier ones, so the highest pending index wins.
        if (cr[1]) begin
            air_val = '0;
            for (int i = 0; i < 5; i++) begin
                if (pend[i]) air_val = 5'b00001 << i;
            end
        end
`endif
        air_clr = (fire && rw && (rs == RS_AIR)) ? air_val : 5'b0;
        fall    = sync_prev & ~sync_q[SYNC_STAGES-1];
        // A new edge is OR'd in after the clear so a coincident set is never lost.
        ilr_nxt = mc ? ((ilr & ~air_clr) | fall) : 5'b0;

        ca = 1'b1;
        cb = 1'b1;
        if (mc) begin
            ca = cr[5] ? ~(hs_low | pra_acc) : cr[4];
            cb = cr[7] ? (cnt == 4'd0) : cr[6];
        end
        irq = irq_q;

        rd_dat = 8'h00;
        case (rs)
            RS_PRA:  rd_dat = (port_a & ddr_a) | (pins_a & ~ddr_a);
            RS_PRB:  rd_dat = (port_b & ddr_b) | (pins_b & ~ddr_b);
            RS_PRC:  rd_dat = mc ? {cb, ca, ~irq_q, ilr}
                                 : ((port_c & ddr_c) | (pins_c & ~ddr_c));
            RS_DDRA: rd_dat = ddr_a;
            RS_DDRB: rd_dat = ddr_b;
            RS_DDRC: rd_dat = ddr_c;
            RS_CR:   rd_dat = cr;
            RS_AIR:  rd_dat = {3'b000, air_val};
            default: rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cs_d      <= 1'b0;
            cr        <= 8'h00;
            ilr       <= 5'b0;
            irq_q     <= 1'b0;
            data_out  <= 8'h00;
            hs_low    <= 1'b0;
            cnt       <= 4'd0;
            sync_prev <= 5'h1f;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'h1f;
        end else begin
            cs_d      <= cs;
            sync_q[0] <= pins_c[4:0];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= sync_q[SYNC_STAGES-1];

            if (fire && !rw && (rs == RS_CR)) cr <= cr_wdat;
            if (fire && rw) data_out <= rd_dat;

            ilr   <= ilr_nxt;
            irq_q <= |(ilr_nxt & ddr_c[4:0]);

            // Handshake: a PRA access outranks a simultaneous PC3 falling edge.
            if (!mc || !cr[5])   hs_low <= 1'b0;
            else if (pra_acc)    hs_low <= 1'b1;
            else if (fall[3])    hs_low <= 1'b0;

            if (!mc || !cr[7])   cnt <= 4'd0;
            else if (prb_acc)    cnt <= 4'(PULSE_LEN);
            else if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_tpi_ctrl.sv
// Directed bench for tpi_ctrl: strobes, read-back, interrupts, CA handshake, CB pulse, reset.
module tb_tpi_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       cs;
    logic       rw;
    logic [2:0] rs;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       we_ddr_a, we_ddr_b, we_ddr_c, we_port_a, we_port_b, we_port_c;
    logic [7:0] ddr_a, ddr_b, ddr_c, port_a, port_b, port_c, pins_a, pins_b, pins_c;
    logic       mc, irq, ca, cb;

    int checks = 0;
    int errors = 0;

    tpi_ctrl #(.PULSE_LEN(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .cs(cs), .rw(rw), .rs(rs),
        .data_in(data_in), .data_out(data_out),
        .we_ddr_a(we_ddr_a), .we_ddr_b(we_ddr_b), .we_ddr_c(we_ddr_c),
        .we_port_a(we_port_a), .we_port_b(we_port_b), .we_port_c(we_port_c),
        .ddr_a(ddr_a), .ddr_b(ddr_b), .ddr_c(ddr_c),
        .port_a(port_a), .port_b(port_b), .port_c(port_c),
        .pins_a(pins_a), .pins_b(pins_b), .pins_c(pins_c),
        .mc(mc), .irq(irq), .ca(ca), .cb(cb)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] strobes();
        return {we_ddr_a, we_ddr_b, we_ddr_c, we_port_a, we_port_b, we_port_c};
    endfunction

    // Full access: fire cycle, then cs dropped so the next access can fire.
    task automatic access(input logic r, input logic [2:0] sel, input logic [7:0] d);
        cs = 1'b1; rw = r; rs = sel; data_in = d;
        tick();
        cs = 1'b0;
        tick();
    endtask

    // Starts a PRB write and counts cb-low cycles; optionally re-accesses PRB at loop index reacc.
    task automatic cb_pulse(input int reacc, output int low);
        low = 0;
        cs = 1'b1; rw = 1'b0; rs = 3'd1; data_in = 8'h00;
        tick();
        for (int c = 0; c < 20; c++) begin
            if (cb == 1'b0) low++;
            cs = (c == reacc);
            tick();
        end
        cs = 1'b0;
        tick();
    endtask

    int n;
    int low;

    initial begin
        reset = 1'b1; cs = 1'b0; rw = 1'b1; rs = 3'd0; data_in = 8'h00;
        ddr_a = 8'h00; ddr_b = 8'h00; ddr_c = 8'h00;
        port_a = 8'h00; port_b = 8'h00; port_c = 8'h00;
        pins_a = 8'h00; pins_b = 8'h00; pins_c = 8'hFF;
        tick(); tick();
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_strobes", strobes(), 6'b0);
        chk("rst_mc", mc, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ca", ca, 1'b1);
        chk("rst_cb", cb, 1'b1);
        reset = 1'b0;
        tick();

        // DDRA write strobe: one cycle only, even with cs held high.
        cs = 1'b1; rw = 1'b0; rs = 3'd3; data_in = 8'hF0;
        #1;
        chk("wr_ddra_strobe", strobes(), 6'b100000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wr_ddra_held", strobes(), 6'b0);
        end
        cs = 1'b0;
        tick();

        // PRB read mixes latch and pins by DDR.
        ddr_b = 8'h0F; port_b = 8'hA5; pins_b = 8'h3C;
        access(1'b1, 3'd1, 8'h00);
        chk("rd_prb", data_out, 8'h35);
        access(1'b1, 3'd6, 8'h00);
        chk("rd_cr_reset", data_out, 8'h00);

        // Interrupt mode with priority bit requested.
        ddr_c = 8'h1F;
        access(1'b0, 3'd6, 8'h03);
        access(1'b1, 3'd6, 8'h00);
`ifdef TPI_IRQ_PRIORITY_EN
        chk("rd_cr_03", data_out, 8'h03);
`else
        chk("rd_cr_03", data_out, 8'h01);
`endif
        chk("mc_on", mc, 1'b1);
        pins_c = 8'hED;
        repeat (4) tick();
        chk("irq_set", irq, 1'b1);
        access(1'b1, 3'd2, 8'h00);
        chk("rd_prc_mc", data_out, 8'h12);
        access(1'b1, 3'd7, 8'h00);
`ifdef TPI_IRQ_PRIORITY_EN
        chk("air_first", data_out, 8'h10);
        chk("irq_still", irq, 1'b1);
        access(1'b1, 3'd7, 8'h00);
        chk("air_second", data_out, 8'h02);
`else
        chk("air_all", data_out, 8'h12);
`endif
        chk("irq_cleared", irq, 1'b0);

        // Same edges with IP=0: one read returns and clears both.
        access(1'b0, 3'd6, 8'h01);
        pins_c = 8'hFF;
        repeat (4) tick();
        chk("rise_no_irq", irq, 1'b0);
        pins_c = 8'hED;
        repeat (4) tick();
        access(1'b1, 3'd7, 8'h00);
        chk("air_ip0", data_out, 8'h12);
        chk("irq_ip0_clr", irq, 1'b0);
        access(1'b1, 3'd7, 8'h00);
        chk("air_empty", data_out, 8'h00);

        // CA handshake.
        access(1'b0, 3'd6, 8'h21);
        chk("ca_idle", ca, 1'b1);
        cs = 1'b1; rw = 1'b1; rs = 3'd0;
        #1;
        chk("ca_fire", ca, 1'b0);
        tick();
        cs = 1'b0;
        tick();
        chk("ca_held", ca, 1'b0);
        pins_c = 8'hE5;
        n = 0;
        while (ca == 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("ca_release_in_bound", (n >= 1 && n <= 3), 1'b1);

        // CB pulse: plain and extended.
        access(1'b0, 3'd6, 8'h81);
        chk("cb_idle", cb, 1'b1);
        cb_pulse(-1, low);
        chk("cb_pulse_len", low, 4);
        cb_pulse(1, low);
        chk("cb_pulse_ext", low, 6);

        // Reset during a pulse with all interrupts pending.
        pins_c = 8'hFF;
        repeat (4) tick();
        pins_c = 8'hE0;
        repeat (4) tick();
        chk("irq_all", irq, 1'b1);
        access(1'b1, 3'd2, 8'h00);
        chk("rd_prc_all", data_out, 8'h9F);
        cs = 1'b1; rw = 1'b0; rs = 3'd1;
        tick();
        cs = 1'b0;
        chk("cb_mid_pulse", cb, 1'b0);
        reset = 1'b1;
        tick();
        chk("rst2_cb", cb, 1'b1);
        chk("rst2_irq", irq, 1'b0);
        chk("rst2_data_out", data_out, 8'h00);
        chk("rst2_mc", mc, 1'b0);
        chk("rst2_ca", ca, 1'b1);
        reset = 1'b0;
        tick();
        access(1'b1, 3'd6, 8'h00);
        chk("rst2_cr", data_out, 8'h00);
        access(1'b1, 3'd7, 8'h00);
        chk("rst2_ilr", data_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
